// File: rtl/axi_ip_tx.sv
// axi_ip_tx: puts a 20-byte IPv4 header in front of an AXI-Stream payload and passes the datagram to an Ethernet framer.
// Define AXI_IP_TX_CHECKSUM_EN to compute the header checksum; without it the checksum bytes are 00 00.
module axi_ip_tx #(
  parameter logic [23:0] MAC_MSB = 24'h010203,
  parameter logic [23:0] MAC_LSB = 24'h040506,
  parameter logic [15:0] IP_MSB  = 16'hc0a8,
  parameter logic [15:0] IP_LSB  = 16'h0602,
  parameter logic [7:0]  TTL     = 8'd64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ip_req,
  output logic        ip_ack,
  input  logic [7:0]  ip_protocol,
  input  logic [31:0] ip_dst_ip,
  input  logic [47:0] ip_dst_mac,
  input  logic [15:0] ip_length,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic        eth_req,
  input  logic        eth_ack,
  output logic [47:0] eth_dst_mac,
  output logic [47:0] eth_src_mac,
  output logic [15:0] eth_ethertype,
  output logic [7:0]  eth_axis_tdata,
  output logic        eth_axis_tlast,
  output logic        eth_axis_tvalid,
  input  logic        eth_axis_tready,
  output logic        len_err
);

`ifdef AXI_IP_TX_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, CSUM, FOLD, REQ, HDR, PAYLOAD} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, HDR, PAYLOAD} state_t;
`endif

  state_t      state_reg, state_next;
  logic [4:0]  idx_reg, idx_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [15:0] id_reg;
  logic [7:0]  proto_reg;
  logic [31:0] dst_ip_reg;
  logic [47:0] dst_mac_reg;
  logic [15:0] len_reg;
  logic [15:0] tot_len_reg;
  logic        len_err_reg, len_err_next;
  logic        capture;
  logic        id_inc;
  logic        frame_active;
  logic [15:0] cs_val;

  logic [159:0] hdr_vec;
  logic [7:0]   hdr [20];

  genvar gi;

  // The whole header as one vector; byte 0 is the most significant.
  assign hdr_vec = {8'h45, 8'h00, tot_len_reg, id_reg, 8'h40, 8'h00, TTL, proto_reg,
                    cs_val, IP_MSB, IP_LSB, dst_ip_reg};

  generate
    for (gi = 0; gi < 20; gi++) begin : g_hdr
      assign hdr[gi] = hdr_vec[159 - 8*gi -: 8];
    end
  endgenerate

`ifdef AXI_IP_TX_CHECKSUM_EN
  logic [19:0] acc_reg;
  logic [15:0] cs_reg;
  logic [16:0] fold1;
  logic [16:0] fold2;
  logic [15:0] csum_word [10];

  // Word 5 is the checksum field itself and counts as zero.
  generate
    for (gi = 0; gi < 10; gi++) begin : g_word
      if (gi == 5) begin : g_zero
        assign csum_word[gi] = 16'h0000;
      end else begin : g_hdr_word
        assign csum_word[gi] = hdr_vec[159 - 16*gi -: 16];
      end
    end
  endgenerate

  assign fold1  = {1'b0, acc_reg[15:0]} + {13'h0, acc_reg[19:16]};
  assign fold2  = {1'b0, fold1[15:0]} + {16'h0, fold1[16]};
  assign cs_val = cs_reg;
`else
  assign cs_val = 16'h0000;
`endif

  assign frame_active  = (state_reg == REQ) || (state_reg == HDR) || (state_reg == PAYLOAD);
  assign eth_dst_mac   = frame_active ? dst_mac_reg : 48'h0;
  assign eth_src_mac   = frame_active ? {MAC_MSB, MAC_LSB} : 48'h0;
  assign eth_ethertype = frame_active ? 16'h0800 : 16'h0000;
  assign len_err       = len_err_reg;

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    cnt_next        = cnt_reg;
    len_err_next    = 1'b0;
    capture         = 1'b0;
    id_inc          = 1'b0;
    ip_ack          = 1'b0;
    s_axis_tready   = 1'b0;
    eth_req         = 1'b0;
    eth_axis_tdata  = 8'h00;
    eth_axis_tlast  = 1'b0;
    eth_axis_tvalid = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ip_req) begin
          ip_ack   = 1'b1;
          capture  = 1'b1;
          idx_next = 5'd0;
          cnt_next = 16'd0;
`ifdef AXI_IP_TX_CHECKSUM_EN
          state_next = CSUM;
`else
          state_next = REQ;
`endif
        end
      end
`ifdef AXI_IP_TX_CHECKSUM_EN
      CSUM: begin
        if (idx_reg == 5'd9) begin
          idx_next   = 5'd0;
          state_next = FOLD;
        end else begin
          idx_next = idx_reg + 5'd1;
        end
      end
      FOLD: state_next = REQ;
`endif
      REQ: begin
        eth_req = 1'b1;
        if (eth_ack) state_next = HDR;
      end
      HDR: begin
        eth_axis_tvalid = 1'b1;
        eth_axis_tdata  = hdr[idx_reg];
        eth_axis_tlast  = (idx_reg == 5'd19) && (len_reg == 16'd0);
        if (eth_axis_tready) begin
          if (idx_reg == 5'd19) begin
            id_inc     = 1'b1;
            idx_next   = 5'd0;
            state_next = (len_reg == 16'd0) ? IDLE : PAYLOAD;
          end else begin
            idx_next = idx_reg + 5'd1;
          end
        end
      end
      PAYLOAD: begin
        eth_axis_tvalid = s_axis_tvalid;
        eth_axis_tdata  = s_axis_tdata;
        eth_axis_tlast  = s_axis_tlast;
        s_axis_tready   = eth_axis_tready;
        if (s_axis_tvalid && eth_axis_tready) begin
          cnt_next = cnt_reg + 16'd1;
          if (s_axis_tlast) begin
            // Length mismatch is only reported; the frame still ends on the source's tlast.
            len_err_next = (cnt_reg + 16'd1) != len_reg;
            state_next   = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (reset) ip_ack = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      idx_reg     <= 5'd0;
      cnt_reg     <= 16'd0;
      id_reg      <= 16'h0000;
      proto_reg   <= 8'h00;
      dst_ip_reg  <= 32'h0;
      dst_mac_reg <= 48'h0;
      len_reg     <= 16'h0;
      tot_len_reg <= 16'h0;
      len_err_reg <= 1'b0;
`ifdef AXI_IP_TX_CHECKSUM_EN
      acc_reg     <= 20'h0;
      cs_reg      <= 16'h0;
`endif
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      cnt_reg     <= cnt_next;
      len_err_reg <= len_err_next;
      if (capture) begin
        proto_reg   <= ip_protocol;
        dst_ip_reg  <= ip_dst_ip;
        dst_mac_reg <= ip_dst_mac;
        len_reg     <= ip_length;
        tot_len_reg <= ip_length + 16'd20;
      end
      if (id_inc) id_reg <= id_reg + 16'd1;
`ifdef AXI_IP_TX_CHECKSUM_EN
      if (capture) acc_reg <= 20'h0;
      else if (state_reg == CSUM) acc_reg <= acc_reg + {4'h0, csum_word[idx_reg[3:0]]};
      if (state_reg == FOLD) cs_reg <= ~fold2[15:0];
`endif
    end
  end

endmodule

// File: tb/tb_axi_ip_tx.sv
// Self-checking bench for axi_ip_tx: randomized frames compared against a byte-level datagram model.
module tb_axi_ip_tx;
  logic        clk = 1'b0;
  logic        reset;
  logic        ip_req;
  logic        ip_ack;
  logic [7:0]  ip_protocol;
  logic [31:0] ip_dst_ip;
  logic [47:0] ip_dst_mac;
  logic [15:0] ip_length;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        eth_req;
  logic        eth_ack;
  logic [47:0] eth_dst_mac;
  logic [47:0] eth_src_mac;
  logic [15:0] eth_ethertype;
  logic [7:0]  eth_axis_tdata;
  logic        eth_axis_tlast;
  logic        eth_axis_tvalid;
  logic        eth_axis_tready;
  logic        len_err;

  int checks   = 0;
  int failures = 0;
  logic [15:0] model_id;
  logic [7:0]  last_bytes[$];

`ifdef AXI_IP_TX_CHECKSUM_EN
  localparam int          EXP_LAT = 12;
  localparam logic [15:0] REF_CS  = 16'hAD7D;
`else
  localparam int          EXP_LAT = 1;
  localparam logic [15:0] REF_CS  = 16'h0000;
`endif
  localparam logic [47:0] SRC_MAC = 48'h010203040506;

  always #5 clk = ~clk;

  axi_ip_tx dut (
    .clk(clk), .reset(reset),
    .ip_req(ip_req), .ip_ack(ip_ack), .ip_protocol(ip_protocol),
    .ip_dst_ip(ip_dst_ip), .ip_dst_mac(ip_dst_mac), .ip_length(ip_length),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .eth_req(eth_req), .eth_ack(eth_ack),
    .eth_dst_mac(eth_dst_mac), .eth_src_mac(eth_src_mac), .eth_ethertype(eth_ethertype),
    .eth_axis_tdata(eth_axis_tdata), .eth_axis_tlast(eth_axis_tlast),
    .eth_axis_tvalid(eth_axis_tvalid), .eth_axis_tready(eth_axis_tready),
    .len_err(len_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Internet checksum as ones-complement sum of 16-bit words.
  function automatic logic [15:0] model_csum(input logic [7:0] h [20]);
    int unsigned s;
    s = 0;
    for (int i = 0; i < 20; i += 2) s += {16'h0, h[i], h[i+1]};
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
`ifdef AXI_IP_TX_CHECKSUM_EN
    return ~s[15:0];
`else
    return 16'h0000;
`endif
  endfunction

  task automatic run_frame(input logic [7:0] proto, input logic [31:0] dip, input logic [47:0] dmac,
                           input logic [15:0] len, input int n_pay, input bit throttle, input int abort_at);
    logic [7:0]  h [20];
    logic [7:0]  exp_q[$];
    logic [7:0]  pay[$];
    logic [7:0]  got_d[$];
    logic [15:0] tl, exp_id, cs;
    logic [7:0]  prev_d;
    logic        prev_l;
    bit          done, prev_stall, aborted;
    int          n_last, lat, cyc, pidx, fld_bad, hold_bad, sready_seen, err_cnt;
    int          bad_bytes, exp_beats, idle_bad, d;
    done = 0; prev_stall = 0; aborted = 0; prev_d = 8'h00; prev_l = 1'b0;
    n_last = 0; cyc = 0; pidx = 0; fld_bad = 0; hold_bad = 0; sready_seen = 0;
    err_cnt = 0; bad_bytes = 0; idle_bad = 0;

    exp_id = model_id;
    tl = len + 16'd20;
    h = '{8'h45, 8'h00, tl[15:8], tl[7:0], exp_id[15:8], exp_id[7:0], 8'h40, 8'h00,
          8'd64, proto, 8'h00, 8'h00, 8'hc0, 8'ha8, 8'h06, 8'h02,
          dip[31:24], dip[23:16], dip[15:8], dip[7:0]};
    cs = model_csum(h);
    h[10] = cs[15:8];
    h[11] = cs[7:0];
    for (int i = 0; i < 20; i++) exp_q.push_back(h[i]);
    for (int i = 0; i < n_pay; i++) begin
      pay.push_back(8'($urandom));
      if (len != 16'd0) exp_q.push_back(pay[i]);
    end
    exp_beats = (len == 16'd0) ? 20 : 20 + n_pay;

    @(negedge clk);
    ip_req = 1'b1; ip_protocol = proto; ip_dst_ip = dip; ip_dst_mac = dmac; ip_length = len;
    #1;
    chk("ip_ack", ip_ack, 1'b1);
    @(negedge clk);
    ip_req = 1'b0;
    ip_protocol = 8'($urandom); ip_dst_ip = $urandom; ip_dst_mac = {16'($urandom), $urandom};
    ip_length = 16'($urandom);
    #1;
    chk("ack_pulse", ip_ack, 1'b0);
    lat = 1;
    while (!eth_req && lat < 40) begin
      @(negedge clk); #1; lat++;
    end
    chk("req_latency", lat, EXP_LAT);
    chk("req_dst_mac", eth_dst_mac, dmac);
    chk("req_src_mac", eth_src_mac, SRC_MAC);
    chk("req_ethertype", eth_ethertype, 16'h0800);

    d = $urandom_range(0, 2);
    for (int k = 0; k < d; k++) begin
      @(negedge clk); #1;
      if (eth_req !== 1'b1) fld_bad++;
    end
    eth_ack = 1'b1;
    @(negedge clk);
    eth_ack = 1'b0;

    while (!done && cyc < 400) begin
      if (abort_at >= 0 && got_d.size() == abort_at) begin
        aborted = 1;
        break;
      end
      eth_axis_tready = throttle ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (pidx < n_pay) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = pay[pidx];
        s_axis_tlast  = (pidx == n_pay - 1);
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'h00;
        s_axis_tlast  = 1'b0;
      end
      #1;
      if (prev_stall && (!eth_axis_tvalid || eth_axis_tdata !== prev_d || eth_axis_tlast !== prev_l))
        hold_bad++;
      if (eth_dst_mac !== dmac || eth_src_mac !== SRC_MAC || eth_ethertype !== 16'h0800 || eth_req !== 1'b0)
        fld_bad++;
      if (s_axis_tready) sready_seen++;
      if (len_err) err_cnt++;
      if (eth_axis_tvalid && eth_axis_tready) begin
        got_d.push_back(eth_axis_tdata);
        if (eth_axis_tlast) begin
          n_last++;
          done = 1;
        end
      end
      if (s_axis_tvalid && s_axis_tready) pidx++;
      prev_stall = eth_axis_tvalid && !eth_axis_tready;
      prev_d = eth_axis_tdata;
      prev_l = eth_axis_tlast;
      @(negedge clk);
      cyc++;
    end

    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; eth_axis_tready = 1'b1;

    if (aborted) begin
      reset = 1'b1;
      @(negedge clk); #1;
      chk("rst_ctrl_outputs", {ip_ack, s_axis_tready, eth_req, eth_axis_tvalid, eth_axis_tlast, len_err, eth_axis_tdata}, 0);
      chk("rst_dst_mac", eth_dst_mac, 48'h0);
      chk("rst_src_mac", eth_src_mac, 48'h0);
      chk("rst_ethertype", eth_ethertype, 16'h0);
      chk("abort_no_tlast", n_last, 0);
      reset = 1'b0;
      model_id = 16'h0000;
      return;
    end

    for (int k = 0; k < 3; k++) begin
      #1;
      if (len_err) err_cnt++;
      if (eth_axis_tvalid || eth_req || s_axis_tready) idle_bad++;
      @(negedge clk);
    end

    for (int i = 0; i < got_d.size() && i < exp_q.size(); i++)
      if (got_d[i] !== exp_q[i]) bad_bytes++;
    chk("frame_done", done, 1'b1);
    chk("beat_count", got_d.size(), exp_beats);
    chk("byte_mismatches", bad_bytes, 0);
    chk("tlast_count", n_last, 1);
    if (got_d.size() >= 6) chk("hdr_id", {got_d[4], got_d[5]}, exp_id);
    chk("fields_stable", fld_bad, 0);
    chk("stall_hold", hold_bad, 0);
    chk("len_err_pulses", err_cnt, (len != 16'd0 && n_pay != int'(len)) ? 1 : 0);
    chk("payload_consumed", pidx, (len == 16'd0) ? 0 : n_pay);
    if (len == 16'd0) chk("s_tready_never", sready_seen, 0);
    chk("idle_quiet", idle_bad, 0);
    model_id = model_id + 16'd1;
    last_bytes = got_d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; ip_req = 1'b1; ip_protocol = 8'h00; ip_dst_ip = 32'h0; ip_dst_mac = 48'h0;
    ip_length = 16'h0; s_axis_tdata = 8'h00; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
    eth_ack = 1'b0; eth_axis_tready = 1'b1;
    model_id = 16'h0000;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl_outputs", {ip_ack, s_axis_tready, eth_req, eth_axis_tvalid, eth_axis_tlast, len_err, eth_axis_tdata}, 0);
    chk("reset_dst_mac", eth_dst_mac, 48'h0);
    chk("reset_ethertype", eth_ethertype, 16'h0);
    ip_req = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    // Reference datagram with known header bytes.
    run_frame(8'h11, 32'hc0a80601, 48'h0a0b0c0d0e0f, 16'd8, 8, 1'b0, -1);
    chk("ref_checksum", {last_bytes[10], last_bytes[11]}, REF_CS);
    chk("ref_beats", last_bytes.size(), 28);

    // Same request under random downstream throttling.
    run_frame(8'h11, 32'hc0a80601, 48'h0a0b0c0d0e0f, 16'd8, 8, 1'b1, -1);

    // Empty payload: header only, source must not be consumed.
    run_frame(8'h06, $urandom, {16'($urandom), $urandom}, 16'd0, 3, 1'b1, -1);

    // Early source tlast on byte 5 of a declared 8-byte payload.
    run_frame(8'h11, 32'hc0a80601, 48'h112233445566, 16'd8, 5, 1'b0, -1);
    chk("short_beats", last_bytes.size(), 25);

    for (int i = 0; i < 4; i++) begin
      n = $urandom_range(1, 10);
      run_frame(8'($urandom), $urandom, {16'($urandom), $urandom}, 16'(n), n, 1'($urandom), -1);
    end

    // Total-length wrap: 20 + 0xFFF0 -> 0x0004.
    run_frame(8'h01, 32'h0a000001, 48'hdeadbeef0001, 16'hFFF0, 2, 1'b0, -1);
    chk("wrap_total_len", {last_bytes[2], last_bytes[3]}, 16'h0004);

    // ID counter wrap.
    @(negedge clk);
    dut.id_reg <= 16'hFFFF;
    model_id = 16'hFFFF;
    run_frame(8'h11, $urandom, {16'($urandom), $urandom}, 16'd4, 4, 1'b1, -1);
    chk("id_ffff", {last_bytes[4], last_bytes[5]}, 16'hFFFF);
    run_frame(8'h11, $urandom, {16'($urandom), $urandom}, 16'd4, 4, 1'b1, -1);
    chk("id_wrap_0000", {last_bytes[4], last_bytes[5]}, 16'h0000);

    // Reset in the middle of the header, then a clean frame with ID 0.
    run_frame(8'h11, $urandom, {16'($urandom), $urandom}, 16'd6, 6, 1'b0, 7);
    run_frame(8'h11, $urandom, {16'($urandom), $urandom}, 16'd6, 6, 1'b0, -1);
    chk("id_after_reset", {last_bytes[4], last_bytes[5]}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
